// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port instruction/data RAM between instruction fetch and the load/store path.
// One access in flight at a time; round-robin on ties; Moore outputs decoded from registered state.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_e            state_q,    state_d;
    logic [2:0]        cnt_q,      cnt_d;
    owner_e            owner_q,    owner_d;
    owner_e            last_gnt_q, last_gnt_d;
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= OWN_FETCH;
            last_gnt_q <= OWN_DATA;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // NOTE: every next-state signal is defaulted to its register first, so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                // Fetch wins when it is alone or when data was granted last.
                if (if_req && (!d_req || last_gnt_q == OWN_DATA)) begin
                    owner_d    = OWN_FETCH;
                    last_gnt_d = OWN_FETCH;
                    we_d       = 1'b0;
                    addr_d     = if_addr;
                    wdata_d    = '0;
                    state_d    = ISSUE;
                end else if (d_req) begin
                    owner_d    = OWN_DATA;
                    last_gnt_d = OWN_DATA;
                    we_d       = d_we;
                    addr_d     = d_addr;
                    wdata_d    = d_wdata;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = LAT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (owner_q == OWN_FETCH) begin
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = (state_q == ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_valid  = (state_q == DONE) && (owner_q == OWN_FETCH);
    assign d_done    = (state_q == DONE) && (owner_q == OWN_DATA);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule
